// File: rtl/adc_responder_pkg.sv
// Shared types and constants for the LTC2308-style ADC responder:
// FSM states, config word bit positions and the channel map.
package adc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_READY,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   // CH0, single-ended, unipolar, awake
   localparam logic [5:0] CFG_RESET = 6'b100010;

   // Odd/sign bit is the LSB of the channel number, select bits above it
   function automatic logic [2:0] chan_index(input logic [5:0] cfg);
      return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
   endfunction

endpackage

// File: rtl/adc_responder_if.sv
// Serial link between the FPGA-side ADC master and this converter model.
interface adc_responder_if;
   logic ADC_CONVST;
   logic ADC_SCK;
   logic ADC_SDI;
   logic ADC_SDO;

   modport master (output ADC_CONVST, output ADC_SCK, output ADC_SDI, input ADC_SDO);
   modport slave  (input ADC_CONVST, input ADC_SCK, input ADC_SDI, output ADC_SDO);
endinterface

// File: rtl/adc_responder_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall detection
// on the synchronized level.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: every flop here, including the synchronizer chain, gets the async reset.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_responder.sv
// Converter end of the LTC2308-style serial link: sample-and-hold on CONVST,
// fixed conversion time, result out on SDO and a one-frame config pipeline on SDI.
module adc_responder
   import adc_pkg::*;
#(
   parameter int CONV_CYCLES = 80,
   parameter int DATA_BITS   = 12,
   parameter int CFG_BITS    = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clock,
   input  logic                     rst_n,
   adc_responder_if.slave           adc,
   input  logic [8*DATA_BITS-1:0]   sample_data,
   output logic                     busy,
   output logic [CFG_BITS-1:0]      active_cfg,
   output logic                     cfg_err,
   output logic [15:0]              conv_count
);

   localparam int CNT_W  = $clog2(CONV_CYCLES);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam int RISE_W = $clog2(CFG_BITS + 1);
   localparam logic [DATA_BITS-1:0] OFFSET = {1'b1, {(DATA_BITS-1){1'b0}}};

   logic convst_rise, sck_rise, sck_fall, sdi_level;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_convst (
      .clock(clock), .rst_n(rst_n), .din(adc.ADC_CONVST),
      .level(), .rise(convst_rise), .fall()
   );
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
      .clock(clock), .rst_n(rst_n), .din(adc.ADC_SCK),
      .level(), .rise(sck_rise), .fall(sck_fall)
   );
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
      .clock(clock), .rst_n(rst_n), .din(adc.ADC_SDI),
      .level(sdi_level), .rise(), .fall()
   );

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [BIT_W-1:0]       bit_q;
   logic [RISE_W-1:0]      rise_q;
   logic [DATA_BITS-1:0]   hold_q, shreg_q, result;
   logic [CFG_BITS-1:0]    pending_cfg, cfg_sr_q;
   logic                   sdo_q;
   logic                   start_conv, enter_ready, shift_out, end_frame, cfg_take;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      start_conv  = 1'b0;
      enter_ready = 1'b0;
      shift_out   = 1'b0;
      end_frame   = 1'b0;
      case (state_q)
         ST_CONVERT: begin
            if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
               state_d     = ST_READY;
               enter_ready = 1'b1;
            end
         end
         ST_READY: begin
            if (convst_rise) begin
               state_d    = ST_CONVERT;
               start_conv = 1'b1;
            end else if (sck_fall) begin
               state_d   = ST_SHIFT;
               shift_out = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (convst_rise) begin
               state_d    = ST_CONVERT;
               start_conv = 1'b1;
            end else if (sck_fall) begin
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  state_d   = ST_DONE;
                  end_frame = 1'b1;
               end else begin
                  shift_out = 1'b1;
               end
            end
         end
         default: begin
            if (convst_rise) begin
               state_d    = ST_CONVERT;
               start_conv = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      result = hold_q;
      if (!active_cfg[CFG_UNI]) result = hold_q ^ OFFSET;
      if (!active_cfg[CFG_SD])  result = '0;
   end

   // SDI is only listened to during the data phase of a frame, and only for the first word
   assign cfg_take = sck_rise && !start_conv && (rise_q < RISE_W'(CFG_BITS)) &&
                     (state_q == ST_READY || state_q == ST_SHIFT);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         bit_q       <= '0;
         rise_q      <= '0;
         hold_q      <= '0;
         shreg_q     <= '0;
         cfg_sr_q    <= '0;
         sdo_q       <= 1'b0;
         active_cfg  <= CFG_RESET;
         pending_cfg <= CFG_RESET;
         cfg_err     <= 1'b0;
         conv_count  <= '0;
      end else begin
         cfg_err <= 1'b0;
         if (start_conv) begin
            active_cfg <= pending_cfg;
            hold_q     <= sample_data[chan_index(pending_cfg)*DATA_BITS +: DATA_BITS];
            cnt_q      <= '0;
            bit_q      <= '0;
            rise_q     <= '0;
            sdo_q      <= 1'b0;
         end else if (state_q == ST_CONVERT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (enter_ready) begin
            shreg_q <= result;
            sdo_q   <= result[DATA_BITS-1];
         end
         if (shift_out) begin
            shreg_q <= shreg_q << 1;
            sdo_q   <= shreg_q[DATA_BITS-2];
            bit_q   <= bit_q + 1'b1;
         end
         if (end_frame) begin
            sdo_q      <= 1'b0;
            conv_count <= conv_count + 16'd1;
         end
         if (cfg_take) begin
            cfg_sr_q <= {cfg_sr_q[CFG_BITS-2:0], sdi_level};
            rise_q   <= rise_q + 1'b1;
            if (rise_q == RISE_W'(CFG_BITS - 1)) begin
               pending_cfg <= {cfg_sr_q[CFG_BITS-2:0], sdi_level};
               cfg_err     <= ~cfg_sr_q[CFG_BITS-2];
            end
         end
      end
   end

   assign busy        = (state_q == ST_CONVERT);
   assign adc.ADC_SDO = sdo_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: a driver issues CONVST/SCK/SDI frames and queues
// the hand-computed result of each frame; a monitor collects SDO bits and compares.
module tb_adc_responder;
   import adc_pkg::*;

   localparam int CONV_CYCLES = 80;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   adc_responder_if adc_if ();

   logic [95:0] sample_data;
   logic        busy;
   logic [5:0]  active_cfg;
   logic        cfg_err;
   logic [15:0] conv_count;

   adc_responder #(
      .CONV_CYCLES(CONV_CYCLES), .DATA_BITS(12), .CFG_BITS(6), .SYNC_STAGES(2)
   ) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .adc         (adc_if),
      .sample_data (sample_data),
      .busy        (busy),
      .active_cfg  (active_cfg),
      .cfg_err     (cfg_err),
      .conv_count  (conv_count)
   );

   int          passed = 0;
   int          total = 0;
   int          frames_seen = 0;
   int          err_pulses = 0;
   bit          frame_on = 1'b0;
   logic [11:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic set_ch(input int n, input logic [11:0] v);
      sample_data[n*12 +: 12] = v;
   endtask

   // CONVST pulse; measures how many clocks busy stays high, optionally
   // re-pulsing CONVST halfway through the conversion.
   task automatic do_convert(input string name, input bit glitch);
      int n;
      int t;
      @(negedge clock);
      adc_if.ADC_CONVST = 1'b1;
      repeat (2) @(negedge clock);
      adc_if.ADC_CONVST = 1'b0;
      t = 0;
      while (busy !== 1'b1 && t < 20) begin
         @(negedge clock);
         t++;
      end
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         if (glitch && n == 40) adc_if.ADC_CONVST = 1'b1;
         if (glitch && n == 43) adc_if.ADC_CONVST = 1'b0;
         n++;
         @(negedge clock);
      end
      check(name, n, CONV_CYCLES);
   endtask

   // SCK half period is 8 clocks; SDI is set up while SCK is low.
   task automatic frame(input logic [5:0] cfg, input int periods, input bit collect,
                        input logic [11:0] exp);
      if (collect) exp_q.push_back(exp);
      frame_on = collect;
      for (int i = 0; i < periods; i++) begin
         adc_if.ADC_SDI = (i < 6) ? cfg[5-i] : 1'b0;
         repeat (4) @(negedge clock);
         adc_if.ADC_SCK = 1'b1;
         repeat (8) @(negedge clock);
         adc_if.ADC_SCK = 1'b0;
         repeat (4) @(negedge clock);
      end
      frame_on = 1'b0;
   endtask

   // Monitor: the master samples SDO on SCK rise
   initial begin
      logic [11:0] bits;
      logic [11:0] exp;
      int          nb;
      bits = '0;
      nb   = 0;
      forever begin
         @(posedge adc_if.ADC_SCK);
         if (frame_on) begin
            bits = {bits[10:0], adc_if.ADC_SDO};
            nb++;
            if (nb == 12) begin
               nb = 0;
               frames_seen++;
               if (exp_q.size() == 0) begin
                  total++;
                  $display("FAIL frame_unexpected: got %03h, expected no frame", bits);
               end else begin
                  exp = exp_q.pop_front();
                  check("frame_data", {20'd0, bits}, {20'd0, exp});
               end
            end
         end
      end
   end

   always @(negedge clock) if (cfg_err === 1'b1) err_pulses++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int err0;
      adc_if.ADC_CONVST = 1'b0;
      adc_if.ADC_SCK    = 1'b0;
      adc_if.ADC_SDI    = 1'b0;
      sample_data       = '0;
      rst_n             = 1'b0;
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      check("rst_sdo", adc_if.ADC_SDO, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_active_cfg", active_cfg, 6'b100010);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_conv_count", conv_count, 16'd0);

      // Basic conversion of CH0
      set_ch(0, 12'hA5C);
      do_convert("busy_len_a", 1'b0);
      frame(6'b100010, 12, 1'b1, 12'hA5C);
      check("count_a", conv_count, 16'd1);
      check("sdo_idle_a", adc_if.ADC_SDO, 1'b0);

      // Config pipeline: frame B selects CH1 for frame C
      set_ch(0, 12'h7FF);
      set_ch(1, 12'h123);
      do_convert("busy_len_b", 1'b0);
      err0 = err_pulses;
      frame(6'b110010, 12, 1'b1, 12'h7FF);
      check("no_cfg_err_b", err_pulses - err0, 0);
      do_convert("busy_len_c", 1'b0);
      check("active_cfg_c", active_cfg, 6'b110010);
      frame(6'b101100, 12, 1'b1, 12'h123);

      // CH6 bipolar: zero code becomes 12'h800; frame D sends S/D=0
      do_convert("busy_len_d", 1'b0);
      err0 = err_pulses;
      frame(6'b000010, 12, 1'b1, 12'h800);
      check("cfg_err_pulse_d", err_pulses - err0, 1);
      do_convert("busy_len_e", 1'b0);
      check("active_cfg_e", active_cfg, 6'b000010);
      frame(6'b100010, 12, 1'b1, 12'h000);
      check("count_e", conv_count, 16'd5);

      // Abort after 5 SCK periods: no count, pending config unchanged
      set_ch(0, 12'h3C3);
      do_convert("busy_len_f", 1'b0);
      frame(6'b101100, 5, 1'b0, 12'h000);
      do_convert("busy_len_abort", 1'b0);
      check("count_abort", conv_count, 16'd5);
      check("active_cfg_abort", active_cfg, 6'b100010);
      frame(6'b110010, 12, 1'b1, 12'h3C3);
      check("count_g", conv_count, 16'd6);

      // Reset mid-SHIFT: CH1 = 12'h123 leaves bit 8 (=1) on SDO after 3 falls
      do_convert("busy_len_h", 1'b0);
      frame(6'b100010, 3, 1'b0, 12'h000);
      check("sdo_before_rst", adc_if.ADC_SDO, 1'b1);
      check("active_cfg_h", active_cfg, 6'b110010);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sdo", adc_if.ADC_SDO, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_active_cfg", active_cfg, 6'b100010);
      check("async_rst_conv_count", conv_count, 16'd0);
      @(negedge clock);
      rst_n = 1'b1;
      repeat (2) @(negedge clock);

      // CONVST during CONVERT must not restart the conversion timer
      do_convert("busy_len_glitch", 1'b1);
      frame(6'b100010, 12, 1'b1, 12'h3C3);
      check("count_after_rst", conv_count, 16'd1);

      repeat (10) @(negedge clock);
      check("frames_seen", frames_seen, 7);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
